// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the instruction-fetch and data ports.
// Three-state FSM with fetch anti-starvation and a BUSY-state timeout abort.
module mem_port_arbiter #(
    parameter int unsigned DATA_STREAK_MAX = 4,
    parameter int unsigned WAIT_LIMIT      = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        err
);

    localparam int unsigned CNT_W = $clog2(WAIT_LIMIT + 1);
    localparam int unsigned STK_W = $clog2(DATA_STREAK_MAX + 1);
    localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    state_t           r_state;
    logic             r_owner_d;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [STK_W-1:0] r_streak;

    logic w_any_req;
    logic w_grant_d;
    logic w_streak_full;
    logic w_timeout;

    // Data wins ties until it has starved a pending fetch DATA_STREAK_MAX times.
    assign w_any_req     = if_req | d_req;
    assign w_streak_full = (r_streak == STK_W'(DATA_STREAK_MAX));
    assign w_grant_d     = d_req & (~if_req | ~w_streak_full);
    assign w_timeout     = (r_wait_cnt == CNT_W'(WAIT_LIMIT - 1));

    assign stall = (if_req & ~if_valid) | (d_req & ~d_valid);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_owner_d  <= 1'b0;
            r_wait_cnt <= '0;
            r_streak   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            if_rdata   <= 32'h0;
            d_rdata    <= 32'h0;
            if_valid   <= 1'b0;
            d_valid    <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner_d  <= w_grant_d;
                        r_wait_cnt <= '0;
                        mem_req    <= 1'b1;
                        mem_we     <= w_grant_d & d_we;
                        mem_addr   <= w_grant_d ? d_addr : if_addr;
                        mem_wdata  <= w_grant_d ? d_wdata : 32'h0;
                        if (!w_grant_d) begin
                            r_streak <= '0;
                        end else if (if_req && !w_streak_full) begin
                            r_streak <= r_streak + STK_W'(1);
                        end
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mem_ack || w_timeout) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        if_valid <= ~r_owner_d;
                        d_valid  <= r_owner_d;
                        // A late ack on the expiry edge still counts as success.
                        err      <= ~mem_ack;
                        if (!mem_ack) begin
                            r_wait_cnt <= CNT_W'(WAIT_LIMIT);
                            if (r_owner_d) d_rdata  <= ABORT_DATA;
                            else           if_rdata <= ABORT_DATA;
                        end else if (!r_owner_d) begin
                            if_rdata <= mem_rdata;
                        end else if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end
                        r_state <= ST_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if_valid <= 1'b0;
                    d_valid  <= 1'b0;
                    err      <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
